// File: rtl/mult_dual_arbiter_if.sv
// Handshake bundle for mult_dual_arbiter.
//   Requests : reqK_valid/reqK_ready with signed x, signed w and an opaque tag.
//   Responses: rspK_valid/rspK_ready with the signed 16-bit product and the tag.
// master = requester/consumer side, slave = arbiter side.
interface mult_dual_arbiter_if #(
  parameter int TAG_W = 4
);
  logic                    req0_valid;
  logic                    req0_ready;
  logic signed [7:0]       req0_x;
  logic signed [7:0]       req0_w;
  logic        [TAG_W-1:0] req0_tag;

  logic                    req1_valid;
  logic                    req1_ready;
  logic signed [7:0]       req1_x;
  logic signed [7:0]       req1_w;
  logic        [TAG_W-1:0] req1_tag;

  logic                    rsp0_valid;
  logic                    rsp0_ready;
  logic signed [15:0]      rsp0_prod;
  logic        [TAG_W-1:0] rsp0_tag;

  logic                    rsp1_valid;
  logic                    rsp1_ready;
  logic signed [15:0]      rsp1_prod;
  logic        [TAG_W-1:0] rsp1_tag;

  modport master (
    output req0_valid, req0_x, req0_w, req0_tag,
    output req1_valid, req1_x, req1_w, req1_tag,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_prod, rsp0_tag,
    input  rsp1_valid, rsp1_prod, rsp1_tag
  );

  modport slave (
    input  req0_valid, req0_x, req0_w, req0_tag,
    input  req1_valid, req1_x, req1_w, req1_tag,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_prod, rsp0_tag,
    output rsp1_valid, rsp1_prod, rsp1_tag
  );
endinterface

// File: rtl/mult_dual_arbiter.sv
// mult_dual_arbiter: shares one 3-stage packed dual multiplier (a*c, b*c)
// between two 8-bit signed multiply requesters. Results return through one
// response FIFO per requester; issue is credit-gated so the multiplier never
// stalls and no FIFO can overflow.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (readies forced low while asserted)
//   bus   - mult_dual_arbiter_if.slave: two request and two response channels
//
// Configuration macro MULT_DUAL_ARB_PAIR_EN: when defined, two eligible
// requests with equal weights issue together as one packed operation. When
// undefined, every issue is a single round-robin grant.
module mult_dual_arbiter #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  mult_dual_arbiter_if.slave bus
);
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int STAGES = 3;
  localparam int AW     = $clog2(DEPTH);
  localparam int PTR_W  = AW + 1;
  localparam int ENT_W  = PROD_W + TAG_W;
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH);

  // Exact signed 8x8 product; operands are sign-extended first so
  // -128 * -128 = 16384 is representable.
  function automatic logic signed [PROD_W-1:0] mul_exact(
    input logic signed [DATA_W-1:0] x,
    input logic signed [COEF_W-1:0] c
  );
    logic signed [PROD_W-1:0] xe;
    logic signed [PROD_W-1:0] ce;
    xe = PROD_W'(x);
    ce = PROD_W'(c);
    return xe * ce;
  endfunction

  logic                     r_rr_ptr;
  logic [1:0]               r_infl0, r_infl1;
  logic [PTR_W-1:0]         r_wptr0, r_rptr0, r_wptr1, r_rptr1;
  logic [ENT_W-1:0]         r_fifo0 [DEPTH];
  logic [ENT_W-1:0]         r_fifo1 [DEPTH];

  logic                     r_vld_p0, r_vld_p1, r_vld_p2;
  logic                     r_live0_p0, r_live0_p1, r_live0_p2;
  logic                     r_live1_p0, r_live1_p1, r_live1_p2;
  logic [TAG_W-1:0]         r_tag0_p0, r_tag0_p1, r_tag0_p2;
  logic [TAG_W-1:0]         r_tag1_p0, r_tag1_p1, r_tag1_p2;
  logic signed [DATA_W-1:0] r_a_p0, r_b_p0;
  logic signed [COEF_W-1:0] r_c_p0;
  logic signed [PROD_W-1:0] r_prod_ac_p1, r_prod_bc_p1, r_prod_ac_p2, r_prod_bc_p2;

  logic [PTR_W-1:0]         w_occ0, w_occ1;
  logic                     w_elig0, w_elig1, w_pair, w_gnt0, w_gnt1, w_issue;
  logic                     w_empty0, w_empty1, w_full0, w_full1;
  logic                     w_push0, w_push1, w_pop0, w_pop1;
  logic signed [DATA_W-1:0] w_a, w_b;
  logic signed [COEF_W-1:0] w_c;

  assign w_occ0   = r_wptr0 - r_rptr0;
  assign w_occ1   = r_wptr1 - r_rptr1;
  assign w_empty0 = (r_wptr0 == r_rptr0);
  assign w_empty1 = (r_wptr1 == r_rptr1);
  assign w_full0  = (r_wptr0[PTR_W-1] != r_rptr0[PTR_W-1]) && (r_wptr0[AW-1:0] == r_rptr0[AW-1:0]);
  assign w_full1  = (r_wptr1[PTR_W-1] != r_rptr1[PTR_W-1]) && (r_wptr1[AW-1:0] == r_rptr1[AW-1:0]);

  // Credit: an entry is reserved for every op still in the multiplier, so a
  // retiring op always finds room. A pop frees credit only from next cycle.
  assign w_elig0 = rst_n && bus.req0_valid &&
                   (({1'b0, w_occ0} + {{(PTR_W-1){1'b0}}, r_infl0}) < DEPTH_L);
  assign w_elig1 = rst_n && bus.req1_valid &&
                   (({1'b0, w_occ1} + {{(PTR_W-1){1'b0}}, r_infl1}) < DEPTH_L);

  always_comb begin
    w_pair = 1'b0;
`ifdef MULT_DUAL_ARB_PAIR_EN
    w_pair = w_elig0 && w_elig1 && (bus.req0_w == bus.req1_w);
`endif
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_pair) begin
      w_gnt0 = 1'b1;
      w_gnt1 = 1'b1;
    end else if (w_elig0 && (!r_rr_ptr || !w_elig1)) begin
      w_gnt0 = 1'b1;
    end else if (w_elig1) begin
      w_gnt1 = 1'b1;
    end
    w_a = w_gnt0 ? bus.req0_x : '0;
    w_b = w_gnt1 ? bus.req1_x : '0;
    w_c = w_gnt0 ? bus.req0_w : (w_gnt1 ? bus.req1_w : '0);
  end

  assign w_issue        = w_gnt0 || w_gnt1;
  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;

  assign w_push0 = r_vld_p2 && r_live0_p2;
  assign w_push1 = r_vld_p2 && r_live1_p2;
  assign w_pop0  = bus.rsp0_ready && !w_empty0;
  assign w_pop1  = bus.rsp1_ready && !w_empty1;

  // Control state: arbitration pointer, pipeline valid/live, credits, pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= 1'b0;
      r_vld_p0   <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_live0_p0 <= 1'b0;
      r_live0_p1 <= 1'b0;
      r_live0_p2 <= 1'b0;
      r_live1_p0 <= 1'b0;
      r_live1_p1 <= 1'b0;
      r_live1_p2 <= 1'b0;
      r_infl0    <= '0;
      r_infl1    <= '0;
      r_wptr0    <= '0;
      r_rptr0    <= '0;
      r_wptr1    <= '0;
      r_rptr1    <= '0;
    end else begin
      // Paired issue leaves the pointer alone; single issue points at the loser.
      if (w_issue && !w_pair) r_rr_ptr <= w_gnt0;
      // stage p0 -> p1 -> p2
      r_vld_p0   <= w_issue;
      r_live0_p0 <= w_gnt0;
      r_live1_p0 <= w_gnt1;
      r_vld_p1   <= r_vld_p0;
      r_live0_p1 <= r_live0_p0;
      r_live1_p1 <= r_live1_p0;
      r_vld_p2   <= r_vld_p1;
      r_live0_p2 <= r_live0_p1;
      r_live1_p2 <= r_live1_p1;
      r_infl0    <= r_infl0 + {1'b0, w_gnt0} - {1'b0, w_push0};
      r_infl1    <= r_infl1 + {1'b0, w_gnt1} - {1'b0, w_push1};
      if (w_push0) r_wptr0 <= r_wptr0 + PTR_W'(1);
      if (w_pop0)  r_rptr0 <= r_rptr0 + PTR_W'(1);
      if (w_push1) r_wptr1 <= r_wptr1 + PTR_W'(1);
      if (w_pop1)  r_rptr1 <= r_rptr1 + PTR_W'(1);
    end
  end

  // Datapath: operand capture, multiply, output register, FIFO write.
  always_ff @(posedge clk) begin
    // stage p0: operands and tags
    r_a_p0       <= w_a;
    r_b_p0       <= w_b;
    r_c_p0       <= w_c;
    r_tag0_p0    <= bus.req0_tag;
    r_tag1_p0    <= bus.req1_tag;
    // stage p1: products
    r_prod_ac_p1 <= mul_exact(r_a_p0, r_c_p0);
    r_prod_bc_p1 <= mul_exact(r_b_p0, r_c_p0);
    r_tag0_p1    <= r_tag0_p0;
    r_tag1_p1    <= r_tag1_p0;
    // stage p2: multiplier output
    r_prod_ac_p2 <= r_prod_ac_p1;
    r_prod_bc_p2 <= r_prod_bc_p1;
    r_tag0_p2    <= r_tag0_p1;
    r_tag1_p2    <= r_tag1_p1;
    if (w_push0) r_fifo0[r_wptr0[AW-1:0]] <= {r_prod_ac_p2, r_tag0_p2};
    if (w_push1) r_fifo1[r_wptr1[AW-1:0]] <= {r_prod_bc_p2, r_tag1_p2};
  end

  assign bus.rsp0_valid = !w_empty0;
  assign bus.rsp1_valid = !w_empty1;
  assign {bus.rsp0_prod, bus.rsp0_tag} = r_fifo0[r_rptr0[AW-1:0]];
  assign {bus.rsp1_prod, bus.rsp1_tag} = r_fifo1[r_rptr1[AW-1:0]];

  a_no_ovf0: assert property (@(posedge clk) disable iff (!rst_n) !(w_push0 && w_full0));
  a_no_ovf1: assert property (@(posedge clk) disable iff (!rst_n) !(w_push1 && w_full1));

  if (STAGES != 3 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("mult_dual_arbiter: DEPTH must be a power of two >= 4");
  end
endmodule

// File: doc/mult_dual_arbiter.md
# mult_dual_arbiter

Shares one `mult_8bit_dual` packed-DSP multiplier between two independent 8-bit multiply requesters. When both requesters present the same weight in the same cycle, it issues them as one dual (packed) operation. Otherwise it issues a single operation chosen round-robin. Results return on two per-requester response channels, each with its own result FIFO and credit-based issue gating, so the multiplier pipeline never needs a stall. It sits between the conv-layer operand fetch units and the accumulator front end.

## Interface
- `TAG_W`, default 4: width of the opaque request tag returned with each result.
- `DEPTH`, default 4: entries per response FIFO. Must be a power of two, ≥ 4.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 accepted this cycle. Combinational.
- `req0_x` in 8: signed activation.
- `req0_w` in 8: signed weight.
- `req0_tag` in TAG_W: returned unchanged.
- `req1_valid`, `req1_ready`, `req1_x`, `req1_w`, `req1_tag`: same as above, for requester 1.
- `rsp0_valid` out 1: result available for requester 0.
- `rsp0_ready` in 1: consumer pops result.
- `rsp0_prod` out 16: signed product x*w.
- `rsp0_tag` out TAG_W: tag of that request.
- `rsp1_valid`, `rsp1_ready`, `rsp1_prod`, `rsp1_tag`: same as above, for requester 1.

## Operation
- Eligibility: requester k is eligible when `reqk_valid` is high and `occ_k + inflight_k < DEPTH`.
  - `occ_k` is FIFO k occupancy.
  - `inflight_k` is the count of lane-k issues still inside the 3-stage multiplier.
  - A pop in the current cycle is not credited until the next cycle.
- Pair issue: both requesters eligible and `req0_w == req1_w`.
  - Both readies go high. Multiplier inputs: a=`req0_x`, b=`req1_x`, c=`req0_w`.
  - Both lanes are tagged live. The round-robin pointer is unchanged.
- Single issue: pair condition false and at least one requester eligible.
  - Grant goes to the eligible requester indicated by `rr_ptr`, else to the other one.
  - Grant to 0: a=x0, b=0. Grant to 1: a=0, b=x1. c is that requester's weight.
  - Only the granted lane is live. `rr_ptr` is set to the non-granted requester.
- Idle: a=b=c=0, `i_valid` low.
- Multiplier `i_valid` = any issue.
- A 3-deep sideband shift register carries {live0, tag0, live1, tag1} aligned to the multiplier stages.
- On multiplier `o_valid`, each live lane pushes {prod, tag} into its FIFO: `prod_ac` goes to FIFO 0, `prod_bc` goes to FIFO 1. A non-live lane's product is discarded.
- FIFOs are circular with `$clog2(DEPTH)+1`-bit pointers. Full/empty come from pointer MSB compare.
- Push and pop in the same cycle on a non-empty FIFO: occupancy is unchanged.
- Credit gating guarantees no push to a full FIFO. Push-when-full is an assertion failure, never silently dropped.
- `rspk_valid` = FIFO k non-empty. `rspk_prod`/`rspk_tag` come from the head entry.
  - Head data must hold stable while `rspk_valid` is high and `rspk_ready` is low.
- Arithmetic: products are exact signed 8×8 → 16. Full range is supported, including -128 × -128 = 16384.

## Timing
- Request accepted in cycle t (valid & ready) → `rspk_valid` first high in cycle t+4, provided FIFO k was empty.
- Sustained throughput:
  - Pair issue: 1 paired op/cycle.
  - Single issue: 1 op/cycle.
  - Per-requester rate is limited by credits when its consumer stalls.
- Reset values:
  - `rsp0_valid` = `rsp1_valid` = 0.
  - `rr_ptr` = 0 (requester 0 favoured).
  - FIFOs empty, `inflight_0` = `inflight_1` = 0, sideband live bits 0.
- While `rst_n` is low: `req0_ready` = `req1_ready` = 0.
- Reset mid-operation: all in-flight and buffered results are discarded. No response appears after reset release unless a new request is accepted.
- Simultaneous events:
  - Issue and retire on the same lane in one cycle: `inflight_k` is unchanged.
  - Both requesters valid with unequal weights: exactly one is granted per cycle. Each requester waits at most 1 cycle while eligible.

## Configuration
- `MULT_DUAL_ARB_PAIR_EN` defined: weight-match pairing is active as above.
- Not defined: pairing logic is removed. Every issue is single, round-robin only, and at most one `reqk_ready` is high per cycle. Latency, credits and FIFO behaviour are identical.

## Test plan
- Single request: req0 x=-5, w=7, tag=3 in cycle 0 → `rsp0_valid` in cycle 4 with prod=-35, tag=3. `rsp1_valid` stays 0.
- Paired requests: req0 x=-128, req1 x=127, both w=-128, accepted same cycle → cycle 4: `rsp0_prod`=16384, `rsp1_prod`=-16256. With the macro undefined, the two results arrive in cycles 4 and 5.
- Unequal weights, both continuously valid for 8 cycles → grants alternate 0,1,0,1…. Each requester gets 4 results with correct products and tags in order.
- Backpressure, DEPTH=4: `rsp0_ready`=0 and req0 continuously valid → exactly 4 accepts, then `req0_ready` stays 0. Release ready → 4 results pop in order, then issue resumes one cycle after the first pop.
- Reset asserted with 2 ops in flight and 1 buffered → after release, `rsp0_valid`/`rsp1_valid` stay 0 until a new request is accepted. `rr_ptr` favours requester 0.
- Randomised valid/ready on all four channels for 10k cycles, scoreboard against x*w → zero mismatches and no FIFO overflow assertion.
